rr_dec_select: RTL and testbench



---
 rtl/rr_dec_select.sv | 139 +++++++++++++
 tb/tb_rr_dec_select.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/rr_dec_select.sv
// ---------------------------------------------------------------------------
// rr_dec_select
//
// Round-robin arbiter feeding the select inputs of a 3-to-8 enabled decoder.
// Eight request lines compete. The winner's binary index is presented on
// {a,b,c} (a = MSB) with en high. The decoder's one-hot output then acts as
// the grant vector.
//
// Every output comes straight from a flop, so the decoder never sees glitchy
// selects. Each grant is followed by at least one idle cycle (en = 0), so no
// two decoder lines are ever high in the same cycle.
//
// Parameters
//   MAX_HOLD  maximum consecutive cycles one grant may stay active (1..255)
//
// Ports
//   clk      in   rising-edge clock
//   rst      in   asynchronous, active-high reset
//   req      in   [7:0] request lines, req[k] requests index k
//   done     in   grantee releases its grant (only looked at while en = 1)
//   a, b, c  out  granted index, bit 2 / bit 1 / bit 0
//   en       out  grant active, drives the decoder enable
//   timeout  out  one-cycle pulse when a grant is force-released at MAX_HOLD
// ---------------------------------------------------------------------------
module rr_dec_select #(
   parameter int MAX_HOLD = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] req,
   input  logic       done,
   output logic       a,
   output logic       b,
   output logic       c,
   output logic       en,
   output logic       timeout
);

   // A 1-bit encoding makes the state flop itself the en output. en is
   // therefore a registered signal with no decode logic in front of it.
   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);

   state_t     state_q, state_nx;
   logic [2:0] idx_q,   idx_nx;
   logic [2:0] ptr_q,   ptr_nx;
   logic [7:0] cnt_q,   cnt_nx;
   logic       to_q,    to_nx;

   // Round-robin search: start at ptr_q and move upward, wrapping from 7 to 0.
   // The first index with an active request wins.
   logic       found;
   logic [2:0] pick;
   logic [2:0] cand;

   always_comb begin
      found = 1'b0;
      pick  = ptr_q;
      cand  = ptr_q;
      for (int i = 0; i < 8; i++) begin
         cand = ptr_q + 3'(i);   // 3-bit add wraps 7 -> 0
         if (!found && req[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

   // Release conditions for the current grant.
   logic req_held;
   logic hold_hit;
   logic release_now;

   assign req_held    = req[idx_q];
   assign hold_hit    = (cnt_q == HOLD_LIMIT);
   assign release_now = done || !req_held || hold_hit;

   // Next-state and output logic.
   // NOTE: every signal gets a default at the top of the block, so no path
   // leaves one unassigned. That is what keeps synthesis from inferring a latch.
   always_comb begin
      state_nx = state_q;
      idx_nx   = idx_q;     // {a,b,c} holds its value unless a new grant loads it
      ptr_nx   = ptr_q;
      cnt_nx   = cnt_q;
      to_nx    = 1'b0;      // timeout is a single-cycle pulse

      unique case (state_q)
         IDLE: begin
            if (found) begin
               state_nx = GRANT;
               idx_nx   = pick;
               cnt_nx   = 8'd1;
            end
         end
         GRANT: begin
            if (release_now) begin
               state_nx = IDLE;
               ptr_nx   = idx_q + 3'd1;
               // The release is reported as a timeout only when the hold limit
               // was the sole cause.
               to_nx    = hold_hit && !done && req_held;
            end else begin
               cnt_nx   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // NOTE: the state flops are updated with non-blocking assignments. All of
   // them then sample the pre-edge values, whatever order the statements are in.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= 3'd0;
         ptr_q   <= 3'd0;
         cnt_q   <= 8'd0;
         to_q    <= 1'b0;
      end else begin
         state_q <= state_nx;
         idx_q   <= idx_nx;
         ptr_q   <= ptr_nx;
         cnt_q   <= cnt_nx;
         to_q    <= to_nx;
      end
   end

   assign a       = idx_q[2];
   assign b       = idx_q[1];
   assign c       = idx_q[0];
   assign en      = (state_q == GRANT);
   assign timeout = to_q;

endmodule

// File: tb/tb_rr_dec_select.sv
// ---------------------------------------------------------------------------
// tb_rr_dec_select
//
// Directed bench for rr_dec_select, built with MAX_HOLD = 4.
//
// The stimulus process drives req/done. For each grant it expects, it queues
// the index, the number of cycles en should stay high, and the timeout value
// at release.
//
// A separate monitor samples on the falling edge. At each rising en it pops
// one entry and checks the index. At each falling en it checks the run length
// and the timeout value.
// ---------------------------------------------------------------------------
module tb_rr_dec_select;

   logic       clk;
   logic       rst;
   logic [7:0] req;
   logic       done;
   logic       a, b, c, en, timeout;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      int idx;
      int len;
      bit to;
   } exp_t;

   exp_t sb[$];

   rr_dec_select #(.MAX_HOLD(4)) dut (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .done    (done),
      .a       (a),
      .b       (b),
      .c       (c),
      .en      (en),
      .timeout (timeout)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, expected end before 100000");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic exp_grant(input int i, input int l, input bit t);
      sb.push_back('{idx: i, len: l, to: t});
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Monitor: decoupled from stimulus, compares against the scoreboard queue.
   initial begin
      bit   prev_en  = 1'b0;
      bit   have_cur = 1'b0;
      int   run_len  = 0;
      exp_t cur;
      forever begin
         @(negedge clk);
         if (en && !prev_en) begin
            run_len = 1;
            if (sb.size() == 0) begin
               checks++;
               failures++;
               have_cur = 1'b0;
               $display("FAIL unexpected_grant: got index %0d expected no grant (t=%0t)",
                        {a, b, c}, $time);
            end else begin
               cur      = sb.pop_front();
               have_cur = 1'b1;
               check("grant_idx", 32'({a, b, c}), 32'(cur.idx));
               check("timeout_low_in_grant", 32'(timeout), 32'd0);
            end
         end else if (en) begin
            run_len++;
         end else if (prev_en && have_cur) begin
            check("grant_len", 32'(run_len), 32'(cur.len));
            check("release_timeout", 32'(timeout), 32'(cur.to));
            have_cur = 1'b0;
         end
         prev_en = en;
      end
   end

   // Stimulus
   initial begin
      rst  = 1'b0;
      req  = 8'h00;
      done = 1'b0;
      #1 rst = 1'b1;
      #1;
      check("reset_en", 32'(en), 32'd0);
      check("reset_abc", 32'({a, b, c}), 32'd0);
      check("reset_timeout", 32'(timeout), 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;

      // Single request on index 2, then released with done.
      exp_grant(2, 1, 1'b0);
      req = 8'b0000_0100;
      step(1);
      done = 1'b1;
      step(1);
      req  = 8'h00;
      done = 1'b0;

      // The pointer should now be 3, so all requests active gives 3.
      exp_grant(3, 1, 1'b0);
      req  = 8'hFF;
      done = 1'b1;
      step(2);
      req  = 8'h00;
      done = 1'b0;

      // Reset returns the pointer to 0, then a full round-robin.
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      for (int k = 0; k < 8; k++) exp_grant(k, 1, 1'b0);
      exp_grant(0, 1, 1'b0);
      req  = 8'hFF;
      done = 1'b1;
      step(18);
      req  = 8'h00;
      done = 1'b0;

      // Forced release at the hold limit, then an immediate re-grant of 7.
      exp_grant(7, 4, 1'b1);
      exp_grant(7, 1, 1'b0);
      req = 8'b1000_0000;
      step(6);
      done = 1'b1;
      step(1);
      req  = 8'h00;
      done = 1'b0;

      // Wrap-around search: grant 6, then requests {0,1} give 0, then 1.
      exp_grant(6, 1, 1'b0);
      exp_grant(0, 1, 1'b0);
      exp_grant(1, 1, 1'b0);
      req  = 8'b0100_0000;
      done = 1'b1;
      step(2);
      req = 8'b0000_0011;
      step(4);
      req  = 8'h00;
      done = 1'b0;

      // done and a dropped request together on the 4th cycle: no timeout.
      exp_grant(4, 4, 1'b0);
      req = 8'b0001_0000;
      step(4);
      done = 1'b1;
      req  = 8'h00;
      step(1);
      done = 1'b0;

      // Request dropped on the 2nd grant cycle: release, no timeout.
      exp_grant(5, 2, 1'b0);
      req = 8'b0010_0000;
      step(2);
      req = 8'h00;
      step(1);

      // Async reset mid-grant of index 5.
      exp_grant(5, 1, 1'b0);
      req = 8'b0010_0000;
      step(1);
      #5 rst = 1'b1;
      #1;
      check("async_rst_en", 32'(en), 32'd0);
      check("async_rst_abc", 32'({a, b, c}), 32'd0);
      check("async_rst_timeout", 32'(timeout), 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      exp_grant(0, 1, 1'b0);
      req  = 8'hFF;
      done = 1'b1;
      step(2);
      req  = 8'h00;
      done = 1'b0;

      // Drain: give the monitor a bounded number of cycles to consume the queue.
      step(3);
      for (int w = 0; w < 20 && sb.size() != 0; w++) step(1);
      check("scoreboard_empty", 32'(sb.size()), 32'd0);
      check("idle_en_at_end", 32'(en), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
